dual_channel_sink: RTL and testbench



---
 rtl/dual_channel_sink_pkg.sv | 25 ++
 rtl/sink_fifo_2w1r.sv | 60 ++++++
 rtl/dual_channel_sink.sv | 81 ++++++++
 tb/tb_dual_channel_sink.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/dual_channel_sink_pkg.sv
`default_nettype none
// ============================================================
// dual_channel_sink_pkg: shared types and helpers for the sink
// Rev 1.0
// ============================================================
package dual_channel_sink_pkg;

  typedef enum logic {
    SRC_CH1 = 1'b0,
    SRC_CH2 = 1'b1
  } src_e;

  localparam int C_DEFAULT_DW = 32;

  // Saturating add for counters up to 32 bits wide; max_val is the all-ones limit.
  function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                          input logic [1:0]  inc,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, cnt} + {31'b0, inc};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sink_fifo_2w1r.sv
`default_nettype none
// ============================================================
// sink_fifo_2w1r: two-write, one-read show-ahead FIFO
// Rev 1.0
// ============================================================
module sink_fifo_2w1r #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr0_en,
  input  logic [W-1:0]               wr0_data,
  input  logic                       wr1_en,
  input  logic [W-1:0]               wr1_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       empty,
  output logic                       pop,
  output logic [$clog2(DEPTH):0]     level,
  output logic [$clog2(DEPTH):0]     free
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] C_DEPTH = LW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [PW-1:0] w_idx1;

  assign empty   = (r_level == '0);
  assign pop     = rd_en & ~empty;
  assign level   = r_level;
  assign free    = C_DEPTH - r_level + LW'(pop);
  assign rd_data = empty ? '0 : r_mem[r_rptr];
  // Second write lands just after the first when both are taken.
  assign w_idx1  = r_wptr + PW'(wr0_en);

  always_ff @(posedge clk) begin
    if (wr0_en) r_mem[r_wptr] <= wr0_data;
    if (wr1_en) r_mem[w_idx1] <= wr1_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      r_wptr  <= r_wptr + PW'(wr0_en) + PW'(wr1_en);
      r_rptr  <= r_rptr + PW'(pop);
      r_level <= r_level + LW'(wr0_en) + LW'(wr1_en) - LW'(pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/dual_channel_sink.sv
`default_nettype none
// ============================================================
// dual_channel_sink: merges two no-backpressure channels into one stream
// Rev 1.0
// ============================================================
module dual_channel_sink
  import dual_channel_sink_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = C_DEFAULT_DW,
  parameter int CNTW  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DW-1:0]          in1,
  input  logic                   in1_valid,
  input  logic [DW-1:0]          in2,
  input  logic                   in2_valid,
  output logic [DW-1:0]          out,
  output logic                   out_src,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNTW-1:0]        drop_count,
  output logic                   overflow
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [CNTW-1:0] C_CNT_MAX = {CNTW{1'b1}};

  logic [DW:0]      w_head;
  logic             w_empty;
  logic             w_pop;
  logic [LW-1:0]    w_free;
  logic             w_acc1;
  logic             w_acc2;
  logic [1:0]       w_drops;
  logic [CNTW-1:0]  r_drop_count;
  logic             r_overflow;

  // Channel 1 has priority for the last free slot.
  assign w_acc1  = in1_valid & (w_free >= LW'(1));
  assign w_acc2  = in2_valid & ((w_free >= LW'(2)) | ((w_free == LW'(1)) & ~in1_valid));
  assign w_drops = 2'(in1_valid & ~w_acc1) + 2'(in2_valid & ~w_acc2);

  sink_fifo_2w1r #(
    .DEPTH (DEPTH),
    .W     (DW + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr0_en   (w_acc1),
    .wr0_data ({SRC_CH1, in1}),
    .wr1_en   (w_acc2),
    .wr1_data ({SRC_CH2, in2}),
    .rd_en    (out_ready),
    .rd_data  (w_head),
    .empty    (w_empty),
    .pop      (w_pop),
    .level    (level),
    .free     (w_free)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_drop_count <= CNTW'(sat_add(32'(r_drop_count), w_drops, 32'(C_CNT_MAX)));
      if (w_drops != 2'd0) r_overflow <= 1'b1;
    end
  end

  assign out        = w_head[DW-1:0];
  assign out_src    = w_head[DW];
  assign out_valid  = ~w_empty;
  assign drop_count = r_drop_count;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_dual_channel_sink.sv
`default_nettype none
// ============================================================
// tb_dual_channel_sink: scoreboard bench for dual_channel_sink
// Rev 1.0
// ============================================================
module tb_dual_channel_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in1 = '0;
  logic        in1_valid = 1'b0;
  logic [31:0] in2 = '0;
  logic        in2_valid = 1'b0;
  logic [31:0] out;
  logic        out_src;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  level;
  logic [7:0]  drop_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  dual_channel_sink #(.DEPTH(4), .DW(32), .CNTW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in1        (in1),
    .in1_valid  (in1_valid),
    .in2        (in2),
    .in2_valid  (in2_valid),
    .out        (out),
    .out_src    (out_src),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted pop is checked against the oldest expected word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got src=%0d data=%h, expected no word", out_src, out);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({out_src, out} !== e) begin
          errors++;
          $display("FAIL pop_data: got src=%0d data=%h, expected src=%0d data=%h",
                   out_src, out, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v1, input logic [31:0] d1,
                       input logic v2, input logic [31:0] d2, input logic rdy);
    in1_valid = v1; in1 = d1;
    in2_valid = v2; in2 = d2;
    out_ready = rdy;
  endtask

  task automatic push(input logic src, input logic [31:0] d);
    exp_q.push_back({src, d});
  endtask

  initial begin
    tick(); tick();
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_out", out, 32'd0);
    check("rst_out_src", 32'(out_src), 32'd0);
    rst = 1'b0;

    // Single word on channel 1, show-ahead visibility.
    drive(1, 32'h11, 0, 0, 0); push(1'b0, 32'h11);
    tick(); drive(0, 0, 0, 0, 0);
    check("t1_out", out, 32'h11);
    check("t1_src", 32'(out_src), 32'd0);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_level", 32'(level), 32'd1);
    drive(0, 0, 0, 0, 1); tick(); drive(0, 0, 0, 0, 0);
    check("t1_drain", 32'(level), 32'd0);

    // Both channels into empty FIFO; ch1 lands first.
    drive(1, 32'hA, 1, 32'hB, 0); push(1'b0, 32'hA); push(1'b1, 32'hB);
    tick(); drive(0, 0, 0, 0, 0);
    check("t2_level", 32'(level), 32'd2);
    drive(0, 0, 0, 0, 1);
    tick(); check("t2_level_1", 32'(level), 32'd1);
    tick(); check("t2_level_0", 32'(level), 32'd0);
    drive(0, 0, 0, 0, 0);

    // Fill to 3, then both valid with one free slot.
    drive(1, 32'h21, 1, 32'h22, 0); push(1'b0, 32'h21); push(1'b1, 32'h22);
    tick();
    drive(1, 32'h23, 0, 0, 0); push(1'b0, 32'h23);
    tick(); drive(0, 0, 0, 0, 0);
    check("t3_level3", 32'(level), 32'd3);
    drive(1, 32'h24, 1, 32'h25, 0); push(1'b0, 32'h24);
    tick(); drive(0, 0, 0, 0, 0);
    check("t3_level4", 32'(level), 32'd4);
    check("t3_drop", 32'(drop_count), 32'd1);
    check("t3_overflow", 32'(overflow), 32'd1);

    // Full with simultaneous pop: ch1 takes the freed slot, ch2 dropped.
    drive(1, 32'h26, 1, 32'h27, 1); push(1'b0, 32'h26);
    tick(); drive(0, 0, 0, 0, 0);
    check("t4_level", 32'(level), 32'd4);
    check("t4_drop", 32'(drop_count), 32'd2);

    // Saturation: +2 per cycle from 2 reaches 254 after 126 cycles, then pins at 255.
    drive(1, 32'h31, 1, 32'h32, 0);
    repeat (126) tick();
    check("t5_drop_254", 32'(drop_count), 32'd254);
    tick();
    check("t5_drop_255", 32'(drop_count), 32'd255);
    repeat (73) tick();
    check("t5_drop_hold", 32'(drop_count), 32'd255);
    check("t5_level", 32'(level), 32'd4);
    drive(0, 0, 0, 0, 1); tick(); drive(0, 0, 0, 0, 0);
    check("t5_level3", 32'(level), 32'd3);

    // Asynchronous reset between edges discards everything.
    #2 rst = 1'b1;
    #1;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_level", 32'(level), 32'd0);
    check("t6_drop", 32'(drop_count), 32'd0);
    check("t6_overflow", 32'(overflow), 32'd0);
    check("t6_out", out, 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    drive(0, 0, 1, 32'h5, 0); push(1'b1, 32'h5);
    tick(); drive(0, 0, 0, 0, 0);
    check("t6_out_after", out, 32'h5);
    check("t6_src_after", 32'(out_src), 32'd1);
    check("t6_level_after", 32'(level), 32'd1);
    drive(0, 0, 0, 0, 1); tick(); drive(0, 0, 0, 0, 0);
    check("t6_drained", 32'(level), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
